// File: rtl/bus_arbiter_mux_pkg.sv
// Shared constants for the bus arbiter: arbitration modes, default sizes, legacy source indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

   localparam int MODE_FIXED   = 0;
   localparam int MODE_RR      = 1;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_N_SRC    = 8;

   // Legacy control-unit source numbering, usable as force_sel values
   localparam int SRC_X        = 0;
   localparam int SRC_AR       = 1;
   localparam int SRC_PC       = 2;
   localparam int SRC_DR       = 3;
   localparam int SRC_AC       = 4;
   localparam int SRC_IR       = 5;
   localparam int SRC_TR       = 6;
   localparam int SRC_MEM      = 7;

   // Index following k, wrapping back to 0 after n-1
   function automatic int unsigned wrap_next(input int unsigned k, input int unsigned n);
      return (k + 1 >= n) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Request/grant/data bundle between bus sources and the shared-bus arbiter.
// Latency: n/a (wires only).
// Backpressure: none; grant is the only flow control a source sees.
interface bus_arbiter_mux_if #(
   parameter int DATA_W = 8,
   parameter int N_SRC  = 8,
   parameter int SEL_W  = $clog2(N_SRC)
);

   logic [N_SRC-1:0]        req;
   logic                    lock;
   logic                    force_en;
   logic [SEL_W-1:0]        force_sel;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [N_SRC-1:0]        grant;
   logic [SEL_W-1:0]        grant_idx;
   logic                    bus_valid;
   logic [DATA_W-1:0]       bus_out;

   // Source side / control unit
   modport master (
      output req, lock, force_en, force_sel, src_data,
      input  grant, grant_idx, bus_valid, bus_out
   );

   // Arbiter side
   modport slave (
      input  req, lock, force_en, force_sel, src_data,
      output grant, grant_idx, bus_valid, bus_out
   );

endinterface

// File: rtl/bus_arbiter_mux_rr_priority_picker.sv
// Finds the first asserted request scanning upward from a start index, wrapping at N_SRC-1.
// Latency: combinational.
// Backpressure: none.
module rr_priority_picker #(
   parameter int N_SRC = 8,
   parameter int SEL_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   int k;

   // Scan from the far end back toward start so the closest hit is the last one written
   always_comb begin
      found = 1'b0;
      idx   = '0;
      k     = 0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         k = int'(start) + i;
         if (k >= N_SRC) begin
            k = k - N_SRC;
         end
         if (req[k]) begin
            found = 1'b1;
            idx   = k[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus controller: arbitrates N_SRC requesters (fixed or round-robin) and muxes the owner's data.
// Latency: 1 cycle from req/force sampling to grant and bus_out.
// Backpressure: none; losing sources simply keep req high until granted.
module bus_arbiter_mux
   import bus_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_SRC  = DEF_N_SRC,
   parameter int SEL_W  = $clog2(N_SRC),
   parameter int MODE   = MODE_FIXED
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_mux_if.slave bus
);

   logic                owner_vld;
   logic [SEL_W-1:0]    owner;
   logic [SEL_W-1:0]    rr_ptr;

   logic                nxt_owner_vld;
   logic [SEL_W-1:0]    nxt_owner;
   logic [SEL_W-1:0]    nxt_ptr;
   logic [SEL_W-1:0]    nxt_idx;
   logic [N_SRC-1:0]    nxt_grant;
   logic [DATA_W-1:0]   nxt_out;

   logic [N_SRC-1:0]    grant_q;
   logic [SEL_W-1:0]    idx_q;
   logic                vld_q;
   logic [DATA_W-1:0]   out_q;

   logic [SEL_W-1:0]    pick_start;
   logic                pick_found;
   logic [SEL_W-1:0]    pick_idx;
   logic                force_ok;
   logic                hold;

   // Fixed priority is round-robin with the search pinned at index 0
   assign pick_start = (MODE == MODE_RR) ? rr_ptr : '0;

   rr_priority_picker #(
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_picker (
      .req   (bus.req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // An out-of-range forced select parks the bus rather than aliasing onto a real source
   assign force_ok = ({1'b0, bus.force_sel} < (SEL_W + 1)'(N_SRC));

   // Lock only keeps an owner that is still asking for the bus
   assign hold = owner_vld && bus.lock && bus.req[owner];

   // Next owner selection: force, then lock hold, then arbitration, else idle
   always_comb begin
      nxt_owner_vld = 1'b0;
      nxt_owner     = owner;
      nxt_ptr       = rr_ptr;
      nxt_idx       = idx_q;
      nxt_grant     = '0;
      nxt_out       = '0;

      if (bus.force_en) begin
         if (force_ok) begin
            nxt_owner_vld = 1'b1;
            nxt_owner     = bus.force_sel;
         end
      end else if (hold) begin
         nxt_owner_vld = 1'b1;
         nxt_owner     = owner;
         nxt_ptr       = SEL_W'(wrap_next(int'(owner), N_SRC));
      end else if (pick_found) begin
         nxt_owner_vld = 1'b1;
         nxt_owner     = pick_idx;
         nxt_ptr       = SEL_W'(wrap_next(int'(pick_idx), N_SRC));
      end

      if (nxt_owner_vld) begin
         nxt_idx              = nxt_owner;
         nxt_grant[nxt_owner] = 1'b1;
         nxt_out              = bus.src_data[int'(nxt_owner)*DATA_W +: DATA_W];
      end
   end

   // Owner, pointer and output registers; reset overrides every other input
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_vld <= 1'b0;
         owner     <= '0;
         rr_ptr    <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         vld_q     <= 1'b0;
         out_q     <= '0;
      end else begin
         owner_vld <= nxt_owner_vld;
         owner     <= nxt_owner;
         rr_ptr    <= nxt_ptr;
         grant_q   <= nxt_grant;
         idx_q     <= nxt_idx;
         vld_q     <= nxt_owner_vld;
         out_q     <= nxt_out;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.bus_valid = vld_q;
   assign bus.bus_out   = out_q;

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised, registered shared-bus controller for the datapath. Replaces a purely combinational source-select mux.
- N_SRC sources raise requests. The block arbitrates (fixed-priority or round-robin), drives a one-hot grant, and registers the winning source's data onto bus_out.
- A force path keeps the legacy "control unit selects the source" operation available.
- Sits between the register file / memory read ports and all bus loaders.

Parameters:
- DATA_W, 8, bus data width in bits
- N_SRC, 8, number of bus sources (2..16)
- SEL_W, $clog2(N_SRC), width of source index
- MODE, 0, arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N_SRC  per-source bus request
- lock  input  1  current owner keeps bus while its req stays high
- force_en  input  1  bypass arbitration, use force_sel
- force_sel  input  SEL_W  forced source index (legacy select)
- src_data  input  N_SRC*DATA_W  flattened source data, source k at bits [k*DATA_W +: DATA_W]
- grant  output  N_SRC  registered one-hot grant
- grant_idx  output  SEL_W  registered index of owner
- bus_valid  output  1  registered: bus_out carries granted data
- bus_out  output  DATA_W  registered bus data

Behaviour:
- Reset: one clock and a synchronous active-high reset; reset is sampled on the rising edge of clk.
  - On reset: grant=0, grant_idx=0, bus_valid=0, bus_out=0, rr pointer=0, owner-valid=0.
  - Reset dominates force_en, req and lock in the same cycle.
- Latency: 1 cycle. req/force sampled at edge t gives grant and bus_out valid after edge t.
- Data tracking: while a source is granted, bus_out <= src_data[owner] every cycle, so it follows source data with 1-cycle delay.
- Next-owner priority, evaluated each cycle:
  1. force_en=1:
     - force_sel < N_SRC: owner=force_sel and bus_valid=1, regardless of req.
     - force_sel >= N_SRC: grant=0, bus_valid=0, bus_out=0.
     - The rr pointer is not updated.
  2. Hold: owner-valid, lock=1 and req[owner]=1 -> the same owner is kept, with no re-arbitration.
  3. Arbitration among asserted req:
     - MODE 0: lowest asserted index wins.
     - MODE 1: search starts at rr pointer, wrapping N_SRC-1 -> 0. After a non-forced grant to k, pointer <= (k+1) mod N_SRC.
  4. No req asserted: grant=0, grant_idx holds its last value, bus_valid=0, bus_out=0.
- Grant lifetime:
  - Without lock, re-arbitration occurs every cycle. A continuous requester may keep the bus in MODE 0; in MODE 1 it may not if others request.
  - Owner dropping req releases the bus on the next edge even if lock=1.
- Invariants:
  - grant is zero or exactly one-hot.
  - grant[grant_idx]=1 whenever bus_valid=1.
  - bus_valid=0 implies bus_out=0.
- Forced-cycle side effects:
  - Owner-valid follows the forced grant.
  - A later lock may hold a force-granted source only if its req is high.
- Simultaneous force_en and lock: force wins.
- N_SRC not a power of two: indices >= N_SRC are never granted.

Decomposition:
- Shared package bus_pkg:
  - MODE_FIXED=0, MODE_RR=1
  - default DATA_W/N_SRC
  - source index constants SRC_X=0, SRC_AR=1, SRC_PC=2, SRC_DR=3, SRC_AC=4, SRC_IR=5, SRC_TR=6, SRC_MEM=7
- One sub-module: rr_priority_picker.
  - Combinational: req vector + start pointer -> found flag + winning index.
  - MODE 0 drives start pointer = 0.
- Top level holds the owner, pointer and output registers and the data mux.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with req=8'hFF -> all outputs 0. Then req=0 -> bus_valid stays 0, bus_out=0.
- Fixed priority: MODE 0, req=8'b1001_0100, src_data[2]=8'h3C -> next edge grant=8'h04, grant_idx=2, bus_out=8'h3C. Change src_data[2] to 8'h5A -> bus_out=8'h5A one cycle later.
- Round-robin fairness: MODE 1, req=8'b0000_1011 held for 6 cycles -> grant_idx sequence 0,1,3,0,1,3.
- Lock/release: MODE 1, source 4 granted, lock=1, req=8'h1F -> grant stays 8'h10 for 5 cycles. Drop req[4] -> next grant_idx=0 (pointer=5, wrap).
- Force path: force_en=1, force_sel=7, req=0, src_data[7]=8'hA5 -> grant=8'h80, bus_valid=1, bus_out=8'hA5. With N_SRC=6, force_sel=7 -> bus_valid=0, bus_out=0.
- Reset mid-grant: source 3 owning with lock=1, assert reset one cycle -> all outputs 0. After release with req=8'h08, MODE 1 -> grant=8'h08 (pointer restarted at 0).
